// File: rtl/asi_ram_sched.sv
// rtl/asi_ram_sched.sv - burst scheduler between ASI write/read request queues and a single-port word RAM
// One burst at a time; reads are fetched with fixed wait states and returned through a one-entry hold register.
module asi_ram_sched #(
    parameter int AW   = 9,
    parameter int BS   = 4,
    parameter int LW   = 8,
    parameter int WS   = 1,
    parameter int ARB  = 0,
    parameter int MAXC = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              wreq_valid,
    output logic              wreq_ready,
    input  logic [AW-1:0]     wreq_addr,
    input  logic [LW-1:0]     wreq_len,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [8*BS-1:0]   wdat_data,
    input  logic [BS-1:0]     wdat_strb,
    output logic              wdone,
    input  logic              rreq_valid,
    output logic              rreq_ready,
    input  logic [AW-1:0]     rreq_addr,
    input  logic [LW-1:0]     rreq_len,
    output logic              rdat_valid,
    input  logic              rdat_ready,
    output logic [8*BS-1:0]   rdat_data,
    output logic              rdat_last,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [BS-1:0]     ram_be,
    output logic [8*BS-1:0]   ram_wdata,
    input  logic [8*BS-1:0]   ram_rdata
);
    localparam int DW = 8 * BS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [2:0]      wait_q, wait_d;
    logic [DW-1:0]   hold_q, hold_d;
    logic [3:0]      streak_q, streak_d;
    logic            wdone_q, wdone_d;
    logic            grant_w, grant_r, pri_wins;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            wait_q     <= '0;
            hold_q     <= '0;
            streak_q   <= '0;
            wdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            wait_q     <= wait_d;
            hold_q     <= hold_d;
            streak_q   <= streak_d;
            wdone_q    <= wdone_d;
        end
    end

    assign wdone = wdone_q;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        wait_d     = wait_q;
        hold_d     = hold_q;
        streak_d   = streak_q;
        wdone_d    = 1'b0;
        grant_w    = 1'b0;
        grant_r    = 1'b0;
        pri_wins   = 1'b0;
        wreq_ready = 1'b0;
        rreq_ready = 1'b0;
        wdat_ready = 1'b0;
        rdat_valid = 1'b0;
        rdat_data  = '0;
        rdat_last  = 1'b0;
        ram_ce     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_be     = '0;
        ram_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                // Grants are suppressed while reset is held so every output reads 0.
                if (!ARESET) begin
                    if (wreq_valid && rreq_valid) begin
                        pri_wins = (streak_q != 4'(MAXC));
                        grant_w  = (ARB == 0) ? pri_wins : !pri_wins;
                        grant_r  = !grant_w;
                        streak_d = pri_wins ? streak_q + 4'd1 : 4'd0;
                    end else if (wreq_valid) begin
                        grant_w  = 1'b1;
                        streak_d = 4'd0;
                    end else if (rreq_valid) begin
                        grant_r  = 1'b1;
                        streak_d = 4'd0;
                    end
                end
                if (grant_w) begin
                    wreq_ready = 1'b1;
                    cur_addr_d = wreq_addr;
                    rem_d      = wreq_len;
                    state_d    = S_WR;
                end else if (grant_r) begin
                    rreq_ready = 1'b1;
                    cur_addr_d = rreq_addr;
                    rem_d      = rreq_len;
                    state_d    = S_RD_REQ;
                end
            end
            S_WR: begin
                wdat_ready = 1'b1;
                if (wdat_valid) begin
                    ram_ce     = 1'b1;
                    ram_we     = 1'b1;
                    ram_addr   = cur_addr_q;
                    ram_be     = wdat_strb;
                    ram_wdata  = wdat_data;
                    cur_addr_d = cur_addr_q + AW'(1);
                    if (rem_q == '0) begin
                        wdone_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rem_d = rem_q - LW'(1);
                    end
                end
            end
            S_RD_REQ: begin
                ram_ce   = 1'b1;
                ram_addr = cur_addr_q;
                ram_be   = '1;
                wait_d   = 3'(WS - 1);
                state_d  = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q == 3'd0) begin
                    hold_d  = ram_rdata;
                    state_d = S_RD_OUT;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_RD_OUT: begin
                rdat_valid = 1'b1;
                rdat_data  = hold_q;
                rdat_last  = (rem_q == '0);
                if (rdat_ready) begin
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        rem_d      = rem_q - LW'(1);
                        cur_addr_d = cur_addr_q + AW'(1);
                        state_d    = S_RD_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_asi_ram_sched.sv
// tb/tb_asi_ram_sched.sv - self-checking bench for asi_ram_sched
// Instance 0: WS=1, write priority. Instance 1: WS=3, read priority. Both MAXC=4.
module tb_asi_ram_sched;
    localparam int AW = 9, BS = 4, DW = 32, LW = 8, MAXC = 4;

    logic clk = 1'b0;
    logic areset;
    logic init_req;
    always #5 clk = ~clk;

    logic            wreq_valid [2], wreq_ready [2], wdat_valid [2], wdat_ready [2], wdone [2];
    logic            rreq_valid [2], rreq_ready [2], rdat_valid [2], rdat_ready [2], rdat_last [2];
    logic            ram_ce [2], ram_we [2];
    logic [AW-1:0]   wreq_addr [2], rreq_addr [2], ram_addr [2];
    logic [LW-1:0]   wreq_len [2], rreq_len [2];
    logic [DW-1:0]   wdat_data [2], rdat_data [2], ram_wdata [2], ram_rdata [2];
    logic [BS-1:0]   wdat_strb [2], ram_be [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        asi_ram_sched #(.AW(AW), .BS(BS), .LW(LW), .WS(g == 0 ? 1 : 3), .ARB(g), .MAXC(MAXC)) u_dut (
            .ACLK(clk), .ARESET(areset),
            .wreq_valid(wreq_valid[g]), .wreq_ready(wreq_ready[g]), .wreq_addr(wreq_addr[g]), .wreq_len(wreq_len[g]),
            .wdat_valid(wdat_valid[g]), .wdat_ready(wdat_ready[g]), .wdat_data(wdat_data[g]), .wdat_strb(wdat_strb[g]),
            .wdone(wdone[g]),
            .rreq_valid(rreq_valid[g]), .rreq_ready(rreq_ready[g]), .rreq_addr(rreq_addr[g]), .rreq_len(rreq_len[g]),
            .rdat_valid(rdat_valid[g]), .rdat_ready(rdat_ready[g]), .rdat_data(rdat_data[g]), .rdat_last(rdat_last[g]),
            .ram_ce(ram_ce[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]), .ram_be(ram_be[g]),
            .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g])
        );
    end

    function automatic int ws_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] init_word(input int g, input int a);
        return 32'hC0DE_0000 ^ (32'(g) << 12) ^ 32'(a);
    endfunction

    // RAM model: data is presented on ram_rdata only in the cycle exactly WS after the read access.
    logic [DW-1:0] mem [2][512];
    logic          pend [2];
    int            pcnt [2];
    logic [AW-1:0] paddr [2];

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (init_req) begin
                for (int a = 0; a < 512; a++) mem[g][a] <= init_word(g, a);
                pend[g] <= 1'b0;
                pcnt[g] <= 0;
            end else begin
                if (ram_ce[g] && ram_we[g])
                    for (int b = 0; b < BS; b++)
                        if (ram_be[g][b]) mem[g][ram_addr[g]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
                if (ram_ce[g] && !ram_we[g]) begin
                    pend[g]  <= 1'b1;
                    pcnt[g]  <= 1;
                    paddr[g] <= ram_addr[g];
                end else if (pend[g]) begin
                    pcnt[g] <= pcnt[g] + 1;
                end
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++)
            ram_rdata[g] = (pend[g] && pcnt[g] == ws_of(g)) ? mem[g][paddr[g]] : 32'hDEAD_BEEF;
    end

    // Reference: shadow memory of intended contents plus arbitration streak per instance.
    logic [DW-1:0] shadow [2][512];
    int            streak [2];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs(input int g);
        wreq_valid[g] = 1'b0; wreq_addr[g] = '0; wreq_len[g] = '0;
        wdat_valid[g] = 1'b0; wdat_data[g] = '0; wdat_strb[g] = '0;
        rreq_valid[g] = 1'b0; rreq_addr[g] = '0; rreq_len[g] = '0;
        rdat_ready[g] = 1'b0;
    endtask

    task automatic zero_chk(input int g, input string tag);
        chk($sformatf("%s u%0d ctrl outs", tag, g),
            {wreq_ready[g], wdat_ready[g], wdone[g], rreq_ready[g], rdat_valid[g], rdat_last[g],
             ram_ce[g], ram_we[g], ram_be[g], ram_addr[g]}, '0);
        chk($sformatf("%s u%0d data outs", tag, g), {rdat_data[g], ram_wdata[g]}, '0);
    endtask

    task automatic grant(input int g, input bit wv, input bit rv, input logic [AW-1:0] wa, input logic [LW-1:0] wl,
                         input logic [AW-1:0] ra, input logic [LW-1:0] rl, output bit gw, output bit gr);
        bit ew, er, pri_w, pri_wins;
        @(negedge clk);
        wreq_valid[g] = wv; wreq_addr[g] = wa; wreq_len[g] = wl;
        rreq_valid[g] = rv; rreq_addr[g] = ra; rreq_len[g] = rl;
        pri_w = (g == 0);
        ew = 1'b0; er = 1'b0;
        if (wv && rv) begin
            pri_wins  = (streak[g] != MAXC);
            ew        = pri_wins ? pri_w : !pri_w;
            er        = !ew;
            streak[g] = pri_wins ? streak[g] + 1 : 0;
        end else if (wv || rv) begin
            ew = wv; er = rv;
            streak[g] = 0;
        end
        #1;
        chk($sformatf("u%0d wreq_ready", g), wreq_ready[g], ew);
        chk($sformatf("u%0d rreq_ready", g), rreq_ready[g], er);
        chk($sformatf("u%0d grant cycle idle", g), {wdat_ready[g], ram_ce[g], rdat_valid[g]}, 3'b000);
        gw = wreq_ready[g];
        gr = rreq_ready[g];
    endtask

    task automatic write_body(input int g, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                              input logic [DW-1:0] base, input bit rnd, input bit gaps);
        int beat = 0, cyc = 0;
        logic v;
        logic [DW-1:0] d;
        logic [BS-1:0] s;
        logic [AW-1:0] a;
        while (beat <= int'(len) && cyc < 300) begin
            @(negedge clk);
            wreq_valid[g] = 1'b0; rreq_valid[g] = 1'b0;
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            d = rnd ? $urandom : base + 32'(beat);
            s = rnd ? 4'($urandom) : 4'hF;
            wdat_valid[g] = v; wdat_data[g] = d; wdat_strb[g] = s;
            a = 9'(32'(addr) + 32'(beat));
            #1;
            chk($sformatf("u%0d wdat_ready", g), wdat_ready[g], 1'b1);
            if (v) begin
                chk($sformatf("u%0d wr ce/we", g), {ram_ce[g], ram_we[g]}, 2'b11);
                chk($sformatf("u%0d wr addr", g), ram_addr[g], a);
                chk($sformatf("u%0d wr data", g), ram_wdata[g], d);
                chk($sformatf("u%0d wr be", g), ram_be[g], s);
                for (int b = 0; b < BS; b++)
                    if (s[b]) shadow[g][a][8*b +: 8] = d[8*b +: 8];
                beat++;
            end else begin
                chk($sformatf("u%0d wr gap ce", g), ram_ce[g], 1'b0);
            end
            cyc++;
        end
        chk($sformatf("u%0d wr beats taken", g), beat, int'(len) + 1);
        @(negedge clk);
        wdat_valid[g] = 1'b0;
        #1;
        chk($sformatf("u%0d wdone pulse", g), {wdone[g], wdat_ready[g]}, 2'b10);
        @(negedge clk);
        #1;
        chk($sformatf("u%0d wdone cleared", g), wdone[g], 1'b0);
    endtask

    // mode 0: ready held high, 1: toggling, 2: random.
    task automatic read_body(input int g, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input int mode, input int abort_after);
        int beat = 0, cyc = 1, nce = 0, first = -1, last_hs = -1;
        bit rdy;
        logic [AW-1:0] ea;
        while (beat <= int'(len) && cyc < 400) begin
            @(negedge clk);
            wreq_valid[g] = 1'b0; rreq_valid[g] = 1'b0;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            rdat_ready[g] = rdy;
            #1;
            if (ram_ce[g]) begin
                chk($sformatf("u%0d rd we/be", g), {ram_we[g], ram_be[g]}, 5'b0_1111);
                chk($sformatf("u%0d rd addr", g), ram_addr[g], 9'(32'(addr) + 32'(nce)));
                nce++;
            end
            if (rdat_valid[g]) begin
                if (first < 0) begin
                    first = cyc;
                    chk($sformatf("u%0d rd first latency", g), first, ws_of(g) + 2);
                end
                ea = 9'(32'(addr) + 32'(beat));
                chk($sformatf("u%0d rd data", g), rdat_data[g], shadow[g][ea]);
                chk($sformatf("u%0d rd last", g), rdat_last[g], beat == int'(len));
                if (rdy) begin
                    if (mode == 0 && last_hs >= 0)
                        chk($sformatf("u%0d rd beat period", g), cyc - last_hs, ws_of(g) + 2);
                    last_hs = cyc;
                    beat++;
                    if (beat == abort_after) break;
                end
            end
            cyc++;
        end
        if (abort_after < 0) begin
            chk($sformatf("u%0d rd beats returned", g), beat, int'(len) + 1);
            chk($sformatf("u%0d rd ram accesses", g), nce, int'(len) + 1);
            @(negedge clk);
            rdat_ready[g] = 1'b0;
            #1;
            chk($sformatf("u%0d rd back to idle", g), rdat_valid[g], 1'b0);
        end
    endtask

    typedef struct {
        int g;
        bit wv;
        bit rv;
        bit ew;
    } arb_vec_t;

    arb_vec_t tbl [23];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit gw, gr, wv, rv;
        logic [AW-1:0] wa, ra;
        logic [LW-1:0] wl, rl;

        tbl = '{
            '{0, 1'b1, 1'b1, 1'b1}, '{0, 1'b1, 1'b1, 1'b1}, '{0, 1'b1, 1'b1, 1'b1}, '{0, 1'b1, 1'b1, 1'b1},
            '{0, 1'b1, 1'b1, 1'b0}, '{0, 1'b1, 1'b1, 1'b1}, '{0, 1'b1, 1'b0, 1'b1}, '{0, 1'b1, 1'b1, 1'b1},
            '{0, 1'b0, 1'b1, 1'b0}, '{0, 1'b1, 1'b1, 1'b1}, '{0, 1'b1, 1'b1, 1'b1}, '{0, 1'b1, 1'b1, 1'b1},
            '{0, 1'b1, 1'b1, 1'b1}, '{0, 1'b1, 1'b1, 1'b0}, '{0, 1'b0, 1'b0, 1'b0},
            '{1, 1'b1, 1'b1, 1'b0}, '{1, 1'b1, 1'b1, 1'b0}, '{1, 1'b1, 1'b1, 1'b0}, '{1, 1'b1, 1'b1, 1'b0},
            '{1, 1'b1, 1'b1, 1'b1}, '{1, 1'b1, 1'b1, 1'b0}, '{1, 1'b1, 1'b0, 1'b1}, '{1, 1'b1, 1'b1, 1'b0}
        };

        areset = 1'b1;
        init_req = 1'b1;
        for (int g = 0; g < 2; g++) begin
            clear_inputs(g);
            streak[g] = 0;
            for (int a = 0; a < 512; a++) shadow[g][a] = init_word(g, a);
        end
        wreq_valid[0] = 1'b1;
        rreq_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        zero_chk(0, "reset");
        zero_chk(1, "reset");
        @(negedge clk);
        areset = 1'b0;
        init_req = 1'b0;
        clear_inputs(0);
        clear_inputs(1);

        // Directed bursts: basic write/read, address wrap with ready toggling, WS=3 latency, write gaps.
        grant(0, 1'b1, 1'b0, 9'd10, 8'd3, 9'd0, 8'd0, gw, gr);
        if (gw) write_body(0, 9'd10, 8'd3, 32'hA0, 1'b0, 1'b0);
        grant(0, 1'b0, 1'b1, 9'd0, 8'd0, 9'd10, 8'd3, gw, gr);
        if (gr) read_body(0, 9'd10, 8'd3, 0, -1);
        chk("u0 ram word 13", mem[0][13], 32'hA3);
        grant(0, 1'b1, 1'b0, 9'd510, 8'd3, 9'd0, 8'd0, gw, gr);
        if (gw) write_body(0, 9'd510, 8'd3, 32'h0, 1'b1, 1'b0);
        grant(0, 1'b0, 1'b1, 9'd0, 8'd0, 9'd510, 8'd3, gw, gr);
        if (gr) read_body(0, 9'd510, 8'd3, 1, -1);
        grant(1, 1'b1, 1'b0, 9'd100, 8'd0, 9'd0, 8'd0, gw, gr);
        if (gw) write_body(1, 9'd100, 8'd0, 32'h1234_5678, 1'b0, 1'b0);
        grant(1, 1'b0, 1'b1, 9'd0, 8'd0, 9'd100, 8'd0, gw, gr);
        if (gr) read_body(1, 9'd100, 8'd0, 0, -1);
        grant(1, 1'b1, 1'b0, 9'd200, 8'd5, 9'd0, 8'd0, gw, gr);
        if (gw) write_body(1, 9'd200, 8'd5, 32'h0, 1'b1, 1'b1);
        grant(1, 1'b0, 1'b1, 9'd0, 8'd0, 9'd200, 8'd5, gw, gr);
        if (gr) read_body(1, 9'd200, 8'd5, 2, -1);

        // Arbitration vectors, each granted burst is a single beat.
        for (int i = 0; i < 23; i++) begin
            wa = 9'($urandom);
            ra = 9'($urandom);
            grant(tbl[i].g, tbl[i].wv, tbl[i].rv, wa, 8'd0, ra, 8'd0, gw, gr);
            chk($sformatf("arb vec %0d", i), {gw, gr}, {tbl[i].ew, (tbl[i].wv | tbl[i].rv) & !tbl[i].ew});
            if (gw) write_body(tbl[i].g, wa, 8'd0, 32'h0, 1'b1, 1'b0);
            else if (gr) read_body(tbl[i].g, ra, 8'd0, 0, -1);
            else begin
                @(negedge clk);
                clear_inputs(tbl[i].g);
            end
        end

        // Random traffic against the shadow memory and streak model.
        for (int i = 0; i < 60; i++) begin
            int g;
            g  = i % 2;
            wv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 3) != 0);
            if (!wv && !rv) wv = 1'b1;
            wa = 9'($urandom); ra = 9'($urandom);
            wl = 8'($urandom_range(0, 3)); rl = 8'($urandom_range(0, 3));
            grant(g, wv, rv, wa, wl, ra, rl, gw, gr);
            if (gw) write_body(g, wa, wl, 32'h0, 1'b1, 1'($urandom_range(0, 1)));
            else if (gr) read_body(g, ra, rl, 2, -1);
        end

        // Reset in the middle of a 4-beat read, then a fresh write from IDLE.
        grant(0, 1'b1, 1'b0, 9'd0, 8'd3, 9'd0, 8'd0, gw, gr);
        if (gw) write_body(0, 9'd0, 8'd3, 32'h0, 1'b1, 1'b0);
        grant(0, 1'b0, 1'b1, 9'd0, 8'd0, 9'd0, 8'd3, gw, gr);
        if (gr) read_body(0, 9'd0, 8'd3, 0, 1);
        @(negedge clk);
        areset = 1'b1;
        clear_inputs(0);
        #1;
        zero_chk(0, "mid-burst reset");
        repeat (2) @(negedge clk);
        areset = 1'b0;
        streak[0] = 0;
        streak[1] = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("after reset quiet", {ram_ce[0], rdat_valid[0], wdone[0]}, 3'b000);
        end
        grant(0, 1'b1, 1'b0, 9'd300, 8'd1, 9'd0, 8'd0, gw, gr);
        if (gw) write_body(0, 9'd300, 8'd1, 32'h5A5A_0000, 1'b0, 1'b0);
        grant(0, 1'b0, 1'b1, 9'd0, 8'd0, 9'd300, 8'd1, gw, gr);
        if (gr) read_body(0, 9'd300, 8'd1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
